// File: rtl/el2_dec_gpr_mp_ctl_pkg.sv
//------------------------------------------------------------------------------
// Module : el2_dec_gpr_mp_ctl_pkg
// Brief  : Shared constants and write-packet type for the multi-port GPR file.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package el2_dec_gpr_mp_ctl_pkg;

    localparam int EL2_GPR_X0 = 0;

    // Write packet for the default 32 x 32 integration wrapper.
    typedef struct packed {
        logic        wen;
        logic        sb_clr;
        logic [4:0]  addr;
        logic [31:0] data;
    } el2_gpr_wr_pkt_t;

endpackage

`default_nettype wire

// File: rtl/el2_dec_gpr_mp_ctl_sb.sv
//------------------------------------------------------------------------------
// Module : el2_dec_gpr_sb
// Brief  : Busy scoreboard for long-latency writebacks with per-port lookup.
//          Optional macros: RV_GPR_BYPASS_EN, RV_ASSERT_ON.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module el2_dec_gpr_sb
    import el2_dec_gpr_mp_ctl_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 3,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sb_set,
    input  logic [AW-1:0]            sb_addr,
    input  logic [NWR-1:0]           wen,
    input  logic [NWR-1:0][AW-1:0]   waddr,
    input  logic [NWR-1:0]           wsb_clr,
    input  logic [NRD-1:0][AW-1:0]   raddr,
    output logic [NRD-1:0]           rbusy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clears are applied first so a same-cycle set overrides them.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (wen[k] && wsb_clr[k]) begin
                busy_d[waddr[k]] = 1'b0;
            end
        end
        if (sb_set) begin
            busy_d[sb_addr] = 1'b1;
        end
        busy_d[EL2_GPR_X0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rbusy
        logic w_rb;
        always_comb begin
            w_rb = busy_q[raddr[i]];
`ifdef RV_GPR_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (wen[k] && wsb_clr[k] && (waddr[k] == raddr[i]) &&
                    !(sb_set && (sb_addr == raddr[i]))) begin
                    w_rb = 1'b0;
                end
            end
`endif
        end
        assign rbusy[i] = w_rb;
    end

`ifdef RV_ASSERT_ON
    logic w_set_clr_hit;
    always_comb begin
        w_set_clr_hit = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            if (wen[k] && wsb_clr[k] && (waddr[k] == sb_addr)) begin
                w_set_clr_hit = 1'b1;
            end
        end
    end

    a_no_double_set: assert property (@(posedge clk) disable iff (rst)
        (sb_set && (sb_addr != AW'(EL2_GPR_X0)) && busy_q[sb_addr]) |-> w_set_clr_hit);
`endif

endmodule

`default_nettype wire

// File: rtl/el2_dec_gpr_mp_ctl.sv
//------------------------------------------------------------------------------
// Module : el2_dec_gpr_mp_ctl
// Brief  : Multi-port integer register file with busy scoreboard and
//          write-collision detection. Optional macros: RV_GPR_BYPASS_EN,
//          RV_ASSERT_ON.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module el2_dec_gpr_mp_ctl
    import el2_dec_gpr_mp_ctl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 3,
    parameter int CNTW = 16,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD-1:0][AW-1:0]   raddr,
    output logic [NRD-1:0][XLEN-1:0] rdata,
    output logic [NRD-1:0]           rbusy,
    input  logic [NWR-1:0]           wen,
    input  logic [NWR-1:0][AW-1:0]   waddr,
    input  logic [NWR-1:0][XLEN-1:0] wdata,
    input  logic [NWR-1:0]           wsb_clr,
    input  logic                     sb_set,
    input  logic [AW-1:0]            sb_addr,
    output logic                     wr_collision,
    output logic [CNTW-1:0]          collision_cnt,
    input  logic                     collision_clr,
    input  logic                     scan_mode
);

    localparam logic [CNTW-1:0] C_CNT_MAX = '1;

    logic [XLEN-1:0] w_gpr [NREG];
    logic            w_coll;
    logic            coll_q;
    logic [CNTW-1:0] cnt_q;
    logic            w_unused_scan;

    // Enable flops have no gated clock in this model, so scan has nothing to steer.
    assign w_unused_scan = scan_mode;

    assign w_gpr[EL2_GPR_X0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic            w_en;
        logic [XLEN-1:0] gpr_d;
        logic [XLEN-1:0] gpr_q;

        // Later ports overwrite earlier ones, giving the highest index priority.
        always_comb begin
            w_en  = 1'b0;
            gpr_d = '0;
            for (int k = 0; k < NWR; k++) begin
                if (wen[k] && (waddr[k] == AW'(r))) begin
                    w_en  = 1'b1;
                    gpr_d = wdata[k];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                gpr_q <= '0;
            end else if (w_en) begin
                gpr_q <= gpr_d;
            end
        end

        assign w_gpr[r] = gpr_q;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [XLEN-1:0] w_rd;
        always_comb begin
            w_rd = w_gpr[raddr[i]];
`ifdef RV_GPR_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (wen[k] && (waddr[k] == raddr[i]) &&
                    (raddr[i] != AW'(EL2_GPR_X0))) begin
                    w_rd = wdata[k];
                end
            end
`endif
        end
        assign rdata[i] = w_rd;
    end

    el2_dec_gpr_sb #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .wen     (wen),
        .waddr   (waddr),
        .wsb_clr (wsb_clr),
        .raddr   (raddr),
        .rbusy   (rbusy)
    );

    always_comb begin
        w_coll = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            for (int m = k + 1; m < NWR; m++) begin
                if (wen[k] && wen[m] && (waddr[k] == waddr[m]) &&
                    (waddr[k] != AW'(EL2_GPR_X0))) begin
                    w_coll = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            coll_q <= w_coll;
            if (collision_clr) begin
                cnt_q <= '0;
            end else if (w_coll && (cnt_q != C_CNT_MAX)) begin
                cnt_q <= cnt_q + CNTW'(1);
            end
        end
    end

    assign wr_collision  = coll_q;
    assign collision_cnt = cnt_q;

`ifdef RV_ASSERT_ON
    a_no_collision: assert property (@(posedge clk) disable iff (rst) !w_coll);
`endif

endmodule

`default_nettype wire

// File: tb/tb_el2_dec_gpr_mp_ctl.sv
//------------------------------------------------------------------------------
// Module : tb_el2_dec_gpr_mp_ctl
// Brief  : Self-checking bench for el2_dec_gpr_mp_ctl (default and CNTW=4).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_el2_dec_gpr_mp_ctl;

    logic             clk;
    logic             rst;
    logic [1:0][4:0]  raddr;
    logic [1:0][31:0] rdata;
    logic [1:0]       rbusy;
    logic [2:0]       wen;
    logic [2:0][4:0]  waddr;
    logic [2:0][31:0] wdata;
    logic [2:0]       wsb_clr;
    logic             sb_set;
    logic [4:0]       sb_addr;
    logic             wr_collision;
    logic [15:0]      collision_cnt;
    logic             collision_clr;
    logic             scan_mode;

    logic [1:0][31:0] rdata4;
    logic [1:0]       rbusy4;
    logic             wr_collision4;
    logic [3:0]       collision_cnt4;

    int checks   = 0;
    int failures = 0;

    el2_dec_gpr_mp_ctl u_dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wsb_clr(wsb_clr),
        .sb_set(sb_set), .sb_addr(sb_addr), .wr_collision(wr_collision),
        .collision_cnt(collision_cnt), .collision_clr(collision_clr),
        .scan_mode(scan_mode)
    );

    el2_dec_gpr_mp_ctl #(.CNTW(4)) u_dut4 (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata4), .rbusy(rbusy4),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wsb_clr(wsb_clr),
        .sb_set(sb_set), .sb_addr(sb_addr), .wr_collision(wr_collision4),
        .collision_cnt(collision_cnt4), .collision_clr(collision_clr),
        .scan_mode(scan_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model
    logic [31:0] m_reg  [32];
    logic        m_busy [32];
    logic        m_coll;
    int          m_cnt;
    int          m_cnt4;
    bit          model_valid = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_tick();
        bit coll;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[r]  = 32'h0;
                m_busy[r] = 1'b0;
            end
            m_coll = 1'b0;
            m_cnt  = 0;
            m_cnt4 = 0;
            model_valid = 1'b1;
        end else begin
            coll = 1'b0;
            for (int k = 0; k < 3; k++)
                for (int m = k + 1; m < 3; m++)
                    if (wen[k] && wen[m] && waddr[k] == waddr[m] && waddr[k] != 0)
                        coll = 1'b1;
            for (int k = 0; k < 3; k++)
                if (wen[k] && waddr[k] != 0) m_reg[waddr[k]] = wdata[k];
            for (int k = 0; k < 3; k++)
                if (wen[k] && wsb_clr[k] && waddr[k] != 0) m_busy[waddr[k]] = 1'b0;
            if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
            m_coll = coll;
            if (collision_clr) begin
                m_cnt  = 0;
                m_cnt4 = 0;
            end else if (coll) begin
                if (m_cnt  < 65535) m_cnt++;
                if (m_cnt4 < 15)    m_cnt4++;
            end
        end
    endtask

    function automatic logic [31:0] exp_rdata(input int i);
        logic [31:0] v;
        v = (raddr[i] == 0) ? 32'h0 : m_reg[raddr[i]];
`ifdef RV_GPR_BYPASS_EN
        for (int k = 0; k < 3; k++)
            if (wen[k] && waddr[k] == raddr[i] && raddr[i] != 0) v = wdata[k];
`endif
        return v;
    endfunction

    function automatic logic exp_rbusy(input int i);
        logic b;
        b = (raddr[i] == 0) ? 1'b0 : m_busy[raddr[i]];
`ifdef RV_GPR_BYPASS_EN
        for (int k = 0; k < 3; k++)
            if (wen[k] && wsb_clr[k] && waddr[k] == raddr[i] &&
                !(sb_set && sb_addr == raddr[i])) b = 1'b0;
`endif
        return b;
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_rdata%0d", i), rdata[i], exp_rdata(i));
                chk($sformatf("model_rbusy%0d", i), rbusy[i], exp_rbusy(i));
            end
            chk("model_wr_collision", wr_collision, m_coll);
            chk("model_cnt", collision_cnt, m_cnt);
            chk("model_cnt4", collision_cnt4, m_cnt4);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle();
        wen = '0;
        wsb_clr = '0;
        sb_set = 1'b0;
        collision_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        raddr = '0;
        waddr = '0;
        wdata = '0;
        sb_addr = '0;
        scan_mode = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // reset clears preloaded state and beats same-cycle writes
        wen = 3'b011;
        waddr[0] = 5'd5; wdata[0] = 32'h1111_1111;
        waddr[1] = 5'd6; wdata[1] = 32'h2222_2222;
        sb_set = 1'b1; sb_addr = 5'd3;
        tick();
        idle();
        rst = 1'b1;
        wen = 3'b001; waddr[0] = 5'd8; wdata[0] = 32'h0000_ABCD;
        sb_set = 1'b1; sb_addr = 5'd4;
        tick();
        rst = 1'b0;
        idle();
        raddr[0] = 5'd5; raddr[1] = 5'd3;
        @(negedge clk);
        chk("reset_rdata0", rdata[0], 32'h0);
        chk("reset_rbusy1", rbusy[1], 1'b0);
        chk("reset_cnt", collision_cnt, 16'h0);

        // single write
        wen = 3'b001; waddr[0] = 5'd5; wdata[0] = 32'hDEAD_BEEF;
        tick();
        idle();
        @(negedge clk);
        chk("write_x5", rdata[0], 32'hDEAD_BEEF);

        // three-way collision on x7
        wen = 3'b111;
        waddr[0] = 5'd7; wdata[0] = 32'h1;
        waddr[1] = 5'd7; wdata[1] = 32'h2;
        waddr[2] = 5'd7; wdata[2] = 32'h3;
        tick();
        idle();
        raddr[0] = 5'd7;
        @(negedge clk);
        chk("coll_x7_data", rdata[0], 32'h3);
        chk("coll_pulse", wr_collision, 1'b1);
        chk("coll_cnt1", collision_cnt, 16'h1);
        tick();
        @(negedge clk);
        chk("coll_pulse_end", wr_collision, 1'b0);

        // x0 writes and set are dropped, not counted
        wen = 3'b011;
        waddr[0] = 5'd0; wdata[0] = 32'hFFFF_FFFF;
        waddr[1] = 5'd0; wdata[1] = 32'hFFFF_FFFF;
        sb_set = 1'b1; sb_addr = 5'd0;
        raddr[0] = 5'd0;
        tick();
        idle();
        @(negedge clk);
        chk("x0_rdata", rdata[0], 32'h0);
        chk("x0_rbusy", rbusy[0], 1'b0);
        chk("x0_no_coll", wr_collision, 1'b0);
        chk("x0_cnt", collision_cnt, 16'h1);

        // scoreboard lifecycle on x9
        raddr[1] = 5'd9;
        sb_set = 1'b1; sb_addr = 5'd9;
        tick();
        idle();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("sb_busy_c%0d", j), rbusy[1], 1'b1);
            tick();
        end
        wen = 3'b100; wsb_clr = 3'b100; waddr[2] = 5'd9; wdata[2] = 32'h55;
        tick();
        idle();
        @(negedge clk);
        chk("sb_cleared", rbusy[1], 1'b0);
        chk("sb_data", rdata[1], 32'h55);
        sb_set = 1'b1; sb_addr = 5'd9;
        tick();
        idle();
        sb_set = 1'b1; sb_addr = 5'd9;
        wen = 3'b001; wsb_clr = 3'b001; waddr[0] = 5'd9; wdata[0] = 32'h66;
        tick();
        idle();
        @(negedge clk);
        chk("sb_set_wins", rbusy[1], 1'b1);
        chk("sb_set_wins_data", rdata[1], 32'h66);
        wen = 3'b001; wsb_clr = 3'b001; waddr[0] = 5'd9; wdata[0] = 32'h77;
        tick();
        idle();
        @(negedge clk);
        chk("sb_final_clear", rbusy[1], 1'b0);

        // directed pattern of single-port writes, read back one behind
        for (int n = 1; n <= 8; n++) begin
            wen = 3'b000;
            wen[n % 3] = 1'b1;
            waddr[n % 3] = 5'(n + 10);
            wdata[n % 3] = 32'h0101_0101 * n;
            raddr[0] = 5'(n + 9);
            raddr[1] = 5'(n + 10);
            tick();
        end
        idle();

        // saturation with CNTW=4 and clear-over-increment
        for (int n = 0; n < 20; n++) begin
            wen = 3'b011;
            waddr[0] = 5'd10; wdata[0] = 32'(n);
            waddr[1] = 5'd10; wdata[1] = 32'(n + 100);
            tick();
        end
        idle();
        @(negedge clk);
        chk("sat_cnt16", collision_cnt, 16'd21);
        chk("sat_cnt4", collision_cnt4, 4'hF);
        collision_clr = 1'b1;
        wen = 3'b110; waddr[1] = 5'd12; waddr[2] = 5'd12;
        tick();
        idle();
        @(negedge clk);
        chk("clr_cnt16", collision_cnt, 16'd0);
        chk("clr_cnt4", collision_cnt4, 4'h0);
        chk("clr_pulse", wr_collision, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
